// File: rtl/key_repeat.sv
// key_repeat
//
// Turns a debounced, level-valued key into single-cycle command pulses with
// typematic auto-repeat. A press edge gives an immediate pulse. If the key
// stays held and repeat is enabled, a second pulse follows INIT_DELAY cycles
// later. After that, pulses repeat every REPEAT_PERIOD cycles until release.
//
// Parameters
//   INIT_DELAY    cycles from the first pulse to the second (2 .. 2^NBITS-1)
//   REPEAT_PERIOD cycles between later repeat pulses     (2 .. 2^NBITS-1)
//   NBITS         delay counter width
//
// Ports
//   Clk       in   system clock
//   Rst       in   synchronous active-high reset
//   KeyClean  in   debounced key level, 1 = pressed (synchronous to Clk)
//   RepeatEn  in   1 = auto-repeat, 0 = one pulse per press
//   KeyPulse  out  registered one-cycle command pulse
//   KeyHeld   out  registered, high while a press is being tracked
module key_repeat #(
  parameter int INIT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int NBITS         = 24
) (
  input  logic Clk,
  input  logic Rst,
  input  logic KeyClean,
  input  logic RepeatEn,
  output logic KeyPulse,
  output logic KeyHeld
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  // Terminal counts: the counter runs 0 .. N-1, so a pulse lands N edges
  // after the previous one.
  localparam logic [NBITS-1:0] INIT_TERM   = NBITS'(INIT_DELAY - 1);
  localparam logic [NBITS-1:0] REPEAT_TERM = NBITS'(REPEAT_PERIOD - 1);

  logic [1:0]       state;
  logic [NBITS-1:0] count;
  logic             key_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      count    <= '0;
      KeyPulse <= 1'b0;
      KeyHeld  <= 1'b0;
      // Pretend the key was already down, so a key held through reset must
      // be released and pressed again before it produces a pulse.
      key_q    <= 1'b1;
    end else begin
      key_q    <= KeyClean;
      KeyPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (KeyClean && !key_q) begin
            KeyPulse <= 1'b1;
            KeyHeld  <= 1'b1;
            count    <= '0;
            state    <= FIRST;
          end
        end
        FIRST: begin
          // Release has priority over a terminal count on the same edge.
          if (!KeyClean) begin
            state   <= IDLE;
            KeyHeld <= 1'b0;
            count   <= '0;
          end else if (count == INIT_TERM) begin
            // With repeat disabled the counter parks at terminal until release.
            if (RepeatEn) begin
              KeyPulse <= 1'b1;
              count    <= '0;
              state    <= REPEAT;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        REPEAT: begin
          if (!KeyClean) begin
            state   <= IDLE;
            KeyHeld <= 1'b0;
            count   <= '0;
          end else if (!RepeatEn) begin
            // Holding count at 0 makes a later re-enable restart the period.
            count <= '0;
          end else if (count == REPEAT_TERM) begin
            KeyPulse <= 1'b1;
            count    <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          count   <= '0;
          KeyHeld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
module tb_key_repeat;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic KeyClean = 1'b0;
  logic RepeatEn = 1'b1;
  logic KeyPulse;
  logic KeyHeld;

  key_repeat #(
    .INIT_DELAY   (8),
    .REPEAT_PERIOD(4),
    .NBITS        (4)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .KeyClean(KeyClean),
    .RepeatEn(RepeatEn),
    .KeyPulse(KeyPulse),
    .KeyHeld (KeyHeld)
  );

  always #5 Clk = ~Clk;

  // One record per clock edge: inputs sampled by that edge and the outputs
  // required just after it.
  typedef struct {
    logic rst;
    logic key;
    logic rep;
    logic exp_pulse;
    logic exp_held;
    int   scen;
    int   idx;
  } vec_t;

  vec_t vecs[$];
  string scen_name [0:7];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic rst, input logic key, input logic rep,
                     input logic p, input logic h, input int scen, input int idx);
    vec_t v;
    v.rst = rst; v.key = key; v.rep = rep;
    v.exp_pulse = p; v.exp_held = h;
    v.scen = scen; v.idx = idx;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic p, input logic h);
    checks++;
    if (KeyPulse !== p || KeyHeld !== h) begin
      errors++;
      $display("FAIL %s edge %0d: got KeyPulse=%b KeyHeld=%b, required KeyPulse=%b KeyHeld=%b",
               name, idx, KeyPulse, KeyHeld, p, h);
    end
  endtask

  initial begin
    int pulses;
    scen_name[0] = "reset_key_held";
    scen_name[1] = "single_tap";
    scen_name[2] = "hold30_rep1";
    scen_name[3] = "hold30_rep0";
    scen_name[4] = "release_on_terminal";
    scen_name[5] = "reset_mid_repeat";
    scen_name[6] = "repeat_toggle";
    scen_name[7] = "idle";

    // Reset for 2 edges with the key held, then 20 held edges: nothing.
    for (int i = 0; i < 2; i++)  add(1, 1, 1, 0, 0, 0, i);
    for (int i = 0; i < 20; i++) add(0, 1, 1, 0, 0, 0, 2 + i);
    for (int i = 0; i < 2; i++)  add(0, 0, 1, 0, 0, 7, i);

    // Single tap: one pulse, KeyHeld high for one cycle.
    add(0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 1, 2);
    add(0, 0, 1, 0, 0, 1, 3);

    // Hold 30 edges with repeat: pulses after 0, 8, 12, 16, 20, 24, 28.
    for (int i = 0; i < 30; i++)
      add(0, 1, 1, (i == 0 || (i >= 8 && (i % 4) == 0)), 1, 2, i);
    add(0, 0, 1, 0, 0, 2, 30);
    add(0, 0, 1, 0, 0, 2, 31);

    // Hold 30 edges without repeat: only the press pulse.
    for (int i = 0; i < 30; i++) add(0, 1, 0, (i == 0), 1, 3, i);
    add(0, 0, 0, 0, 0, 3, 30);
    add(0, 0, 1, 0, 0, 3, 31);

    // Release sampled on the terminal edge 8, re-press at edge 9.
    for (int i = 0; i < 8; i++) add(0, 1, 1, (i == 0), 1, 4, i);
    add(0, 0, 1, 0, 0, 4, 8);
    add(0, 1, 1, 1, 1, 4, 9);
    add(0, 1, 1, 0, 1, 4, 10);
    add(0, 0, 1, 0, 0, 4, 11);
    add(0, 0, 1, 0, 0, 4, 12);

    // Reset at edge 14 mid-repeat, held key stays silent, then re-press.
    for (int i = 0; i < 14; i++) add(0, 1, 1, (i == 0 || i == 8 || i == 12), 1, 5, i);
    add(1, 1, 1, 0, 0, 5, 14);
    for (int i = 15; i < 20; i++) add(0, 1, 1, 0, 0, 5, i);
    add(0, 0, 1, 0, 0, 5, 20);
    for (int i = 0; i < 10; i++) add(0, 1, 1, (i == 0 || i == 8), 1, 5, 100 + i);
    add(0, 0, 1, 0, 0, 5, 110);
    add(0, 0, 1, 0, 0, 5, 111);

    // RepeatEn off in REPEAT for edges 10..14; back on at 15 restarts the
    // period from 0, so the next pulse is after edge 18, then 22.
    for (int i = 0; i < 10; i++)  add(0, 1, 1, (i == 0 || i == 8), 1, 6, i);
    for (int i = 10; i < 15; i++) add(0, 1, 0, 0, 1, 6, i);
    for (int i = 15; i < 23; i++) add(0, 1, 1, (i == 18 || i == 22), 1, 6, i);
    add(0, 0, 1, 0, 0, 6, 23);
    add(0, 0, 1, 0, 0, 6, 24);

    foreach (vecs[k]) begin
      Rst      = vecs[k].rst;
      KeyClean = vecs[k].key;
      RepeatEn = vecs[k].rep;
      @(posedge Clk);
      #1;
      check(scen_name[vecs[k].scen], vecs[k].idx, vecs[k].exp_pulse, vecs[k].exp_held);
    end

    // Hand-written: a one-cycle tap counted over a window yields exactly one
    // pulse, and it never lasts two consecutive cycles.
    Rst = 1'b0;
    KeyClean = 1'b1;
    pulses = 0;
    @(posedge Clk); #1;
    KeyClean = 1'b0;
    if (KeyPulse === 1'b1) pulses++;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (KeyPulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL tap_pulse_count: got %0d pulses, required 1", pulses);
    end

    // Hand-written: long hold with repeat, count pulses over 40 held edges:
    // edges 0, 8, 12, ..., 36 -> 9 pulses, never two in a row.
    begin
      int    prev;
      int    consec;
      KeyClean = 1'b1;
      RepeatEn = 1'b1;
      pulses = 0;
      prev = 0;
      consec = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge Clk); #1;
        if (KeyPulse === 1'b1) begin
          pulses++;
          if (prev == 1) consec++;
          prev = 1;
        end else begin
          prev = 0;
        end
      end
      KeyClean = 1'b0;
      checks++;
      if (pulses != 9) begin
        errors++;
        $display("FAIL hold40_pulse_count: got %0d pulses, required 9", pulses);
      end
      checks++;
      if (consec != 0) begin
        errors++;
        $display("FAIL no_back_to_back: got %0d back-to-back pulses, required 0", consec);
      end
      @(posedge Clk); #1;
      check("hold40_release", 40, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
